adc_spi_rx_multi: RTL and testbench
===================================

Name: adc_spi_rx_multi

Overview:
- Parametrised successor to the team's serial ADC receiver, but runs as SPI master on the system clock.
- Generates CS and SCLK itself and shifts CH parallel SDATA lines in at once. These lines share one CS/SCLK, e.g. dual AD7476-class converters.
- Extracts a configurable data field, converts offset-binary to two's complement and sign-extends to OUT_W.
- Supports triggered and free-running modes, request queuing and overrun reporting. Feeds downstream DSP/display logic.

Parameters:
- CH, 2, number of SDATA lanes / output channels (≥1)
- FRAME_BITS, 16, SCLK periods per frame (2..64)
- DATA_MSB, 11, frame-register bit index of field MSB (bit 0 = last bit received)
- DATA_BITS, 12, field width; requires DATA_MSB-DATA_BITS+1 ≥ 0
- OUT_W, 16, output width per channel; requires OUT_W ≥ DATA_BITS
- SIGNED_IN, 0, 0 = field is offset binary (invert MSB), 1 = field already two's complement
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- CS_IDLE, 2, minimum CS-high time between frames, in units of CLK_DIV cycles (≥1)
- AVG_LOG2, 2, averaging depth exponent; used only with the optional feature

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle conversion request
- continuous  in  1  1 = free-running back-to-back frames
- SDATA  in  CH  serial data, lane i = channel i
- CS  out  1  chip select, active low
- SCLK  out  1  serial clock, idles high
- busy  out  1  high from LEAD through QUIET
- rx_done_tick  out  1  one-clk pulse, data_out valid/updated
- data_out  out  CH*OUT_W  channel i at [i*OUT_W +: OUT_W]
- overrun_tick  out  1  one-clk pulse when a request is dropped

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-frame):
  - FSM returns to IDLE; CS=1, SCLK=1.
  - busy, rx_done_tick, overrun_tick = 0; data_out = 0.
  - Shift registers, counters and pending flag = 0.
- FSM states:
  - IDLE: CS=1, SCLK=1. Moves to LEAD if start, continuous or pending is set.
  - LEAD: CS=0, SCLK=1 for CLK_DIV cycles, then SHIFT.
  - SHIFT: FRAME_BITS periods, each SCLK low for CLK_DIV cycles then high for CLK_DIV cycles.
    - On the clk edge where SCLK goes 0→1, every lane shifts in: frame_i <= {frame_i[FRAME_BITS-2:0], SDATA[i]}.
    - The bit counter increments on each of these edges.
  - After the FRAME_BITS-th high phase completes: CS goes 1 in that same cycle. rx_done_tick=1 for that one cycle and data_out is loaded in that cycle. Then QUIET.
  - QUIET: CS=1, SCLK=1 for CS_IDLE*CLK_DIV cycles, then IDLE.
    - QUIET goes directly to LEAD if continuous or pending is set; pending clears on entry to LEAD.
- Timing:
  - CS low time = CLK_DIV*(1+2*FRAME_BITS) cycles; defaults give 132.
  - Continuous frame period = CS low time + CS_IDLE*CLK_DIV; defaults give 140.
- Requests:
  - start in IDLE is accepted immediately; continuous overrides start.
  - start while busy with pending=0 and continuous=0: sets pending.
  - start while pending=1: dropped, overrun_tick pulses the next cycle.
  - start while continuous=1 and busy: ignored, no overrun.
- Deasserting continuous mid-frame: the current frame completes normally and no new frame starts unless pending is set.
- Conversion per channel:
  - field = frame_i[DATA_MSB : DATA_MSB-DATA_BITS+1].
  - If SIGNED_IN=0, invert the field MSB.
  - Sign-extend to OUT_W.
- data_out holds its value between rx_done_tick pulses.

Optional Feature:
- Macro ADC_AVG_EN.
- Defined:
  - Per-channel signed accumulator of width OUT_W+AVG_LOG2 and a frame counter.
  - Each frame's converted sample is added to the accumulator.
  - On the 2^AVG_LOG2-th frame: data_out = acc >>> AVG_LOG2 (arithmetic, floor), rx_done_tick pulses, accumulator and counter clear.
  - rx_done_tick is suppressed on all other frames.
  - Reset clears the accumulator and counter.
- Not defined: no accumulator logic; every frame updates data_out and pulses rx_done_tick.

Test Plan:
- Defaults; reset; single start; ADC model drives ch0 frame 16'h0FFF and ch1 frame 16'h0800 → CS low 132 cycles, 16 SCLK rising edges, rx_done_tick once with CS rise, data_out ch0=16'h07FF and ch1=16'h0000.
- ch0 frame 16'h0000, ch1 frame 16'h0801 → ch0=16'hF800 (-2048), ch1=16'h0001. Repeat with SIGNED_IN=1 and frame 16'h0800 → 16'hF800.
- continuous=1 for 3 frames → CS falls every 140 cycles, 3 rx_done_tick pulses, CS high exactly 8 cycles between frames.
- Two start pulses at cycle 20 then a third at cycle 40 during a frame → one queued frame follows after QUIET; overrun_tick pulses once (third start); total 2 frames.
- reset asserted at SCLK edge 7 → CS=1, SCLK=1, data_out=0 immediately; next start yields a clean full 16-bit frame.
- With ADC_AVG_EN and AVG_LOG2=2, ch0 samples 10, 11, 12, 14 → single rx_done_tick after frame 4, ch0=16'd11 (47>>>2).

Source files
------------

// File: rtl/adc_spi_rx_multi.sv
// adc_spi_rx_multi: SPI master receiver for CH ADC lanes sharing CS/SCLK, field extract + sign-extend.
// Optional ADC_AVG_EN adds per-channel averaging over 2^AVG_LOG2 frames.
module adc_spi_rx_multi #(
    parameter int CH         = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_MSB   = 11,
    parameter int DATA_BITS  = 12,
    parameter int OUT_W      = 16,
    parameter int SIGNED_IN  = 0,
    parameter int CLK_DIV    = 4,
    parameter int CS_IDLE    = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [CH-1:0]         SDATA,
    output logic                  CS,
    output logic                  SCLK,
    output logic                  busy,
    output logic                  rx_done_tick,
    output logic [CH*OUT_W-1:0]   data_out,
    output logic                  overrun_tick
);
    localparam logic [1:0] IDLE = 2'd0, LEAD = 2'd1, SHIFT = 2'd2, QUIET = 2'd3;
    localparam int QW = $clog2(CS_IDLE * CLK_DIV + CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [QW-1:0] DIV_END = QW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QUIET_END = QW'(CS_IDLE * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END = BW'(FRAME_BITS);
    localparam logic [DATA_BITS-1:0] MSB_BIT = DATA_BITS'(1) << (DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] FLIP = (SIGNED_IN != 0) ? '0 : MSB_BIT;

    logic [1:0]                  state;
    logic [QW-1:0]               cnt;
    logic [BW-1:0]               bit_cnt;
    logic                        phase;
    logic                        pending;
    logic [FRAME_BITS-1:0]       frame [CH];
    logic signed [OUT_W-1:0]     conv [CH];
    logic                        div_done, quiet_done, go_lead, frame_done, sample;

    assign div_done   = cnt == DIV_END;
    assign quiet_done = cnt == QUIET_END;
    assign go_lead    = (state == IDLE && (start || continuous || pending)) ||
                        (state == QUIET && quiet_done && (continuous || pending));
    assign frame_done = state == SHIFT && phase && div_done && bit_cnt == BIT_END;
    assign sample     = state == SHIFT && !phase && div_done;
    assign CS         = state == IDLE || state == QUIET;
    assign SCLK       = !(state == SHIFT && !phase);
    assign busy       = state != IDLE;

    always_comb begin
        for (int i = 0; i < CH; i++)
            conv[i] = OUT_W'($signed(frame[i][DATA_MSB -: DATA_BITS] ^ FLIP));
    end

    // phase 0 = SCLK low half, phase 1 = SCLK high half
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            phase        <= 1'b0;
            pending      <= 1'b0;
            overrun_tick <= 1'b0;
        end else begin
            overrun_tick <= start && busy && !continuous && pending;
            pending      <= go_lead ? 1'b0 : (start && busy && !continuous) ? 1'b1 : pending;
            if (go_lead) begin
                state <= LEAD;
                cnt   <= '0;
            end else if (state == LEAD && div_done) begin
                state   <= SHIFT;
                cnt     <= '0;
                phase   <= 1'b0;
                bit_cnt <= '0;
            end else if (frame_done) begin
                state <= QUIET;
                cnt   <= '0;
            end else if (state == SHIFT && div_done) begin
                cnt     <= '0;
                phase   <= !phase;
                bit_cnt <= phase ? bit_cnt : bit_cnt + 1'b1;
            end else if (state == QUIET && quiet_done) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++)
                frame[i] <= '0;
        end else if (sample) begin
            for (int i = 0; i < CH; i++)
                frame[i] <= {frame[i][FRAME_BITS-2:0], SDATA[i]};
        end
    end

`ifdef ADC_AVG_EN
    localparam int AW = OUT_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] AVG_LAST = CW'(2 ** AVG_LOG2 - 1);
    logic signed [AW-1:0] acc [CH];
    logic signed [AW-1:0] sum [CH];
    logic [CW-1:0]        avg_cnt;
    logic                 avg_last;

    assign avg_last = avg_cnt == AVG_LAST;

    always_comb begin
        for (int i = 0; i < CH; i++)
            sum[i] = acc[i] + AW'(conv[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            data_out     <= '0;
            avg_cnt      <= '0;
            for (int i = 0; i < CH; i++)
                acc[i] <= '0;
        end else begin
            rx_done_tick <= frame_done && avg_last;
            if (frame_done) begin
                avg_cnt <= avg_last ? '0 : avg_cnt + 1'b1;
                for (int i = 0; i < CH; i++) begin
                    acc[i] <= avg_last ? '0 : sum[i];
                    if (avg_last)
                        data_out[i*OUT_W +: OUT_W] <= OUT_W'(sum[i] >>> AVG_LOG2);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            data_out     <= '0;
        end else begin
            rx_done_tick <= frame_done;
            if (frame_done) begin
                for (int i = 0; i < CH; i++)
                    data_out[i*OUT_W +: OUT_W] <= conv[i];
            end
        end
    end
`endif
endmodule

// File: tb/tb_adc_spi_rx_multi.sv
// tb_adc_spi_rx_multi: directed bench for adc_spi_rx_multi with an MSB-first ADC lane model.
module tb_adc_spi_rx_multi;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, continuous = 1'b0;
    logic [1:0]  SDATA;
    logic        CS, SCLK, busy, rx_done_tick, overrun_tick;
    logic [31:0] data_out;
    logic        cs_s, sclk_s, busy_s, rx_s, ov_s;
    logic [31:0] data_s;
    logic [15:0] w0 = 16'h0, w1 = 16'h0;
    int checks = 0, failures = 0;
    int cyc = 0, rx_cnt = 0, ov_cnt = 0, sclk_rises = 0;
    int low_run = 0, high_run = 0, last_low = 0, last_high = 0, last_fall = 0, fall_period = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;

    adc_spi_rx_multi dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .SDATA(SDATA),
        .CS(CS), .SCLK(SCLK), .busy(busy), .rx_done_tick(rx_done_tick),
        .data_out(data_out), .overrun_tick(overrun_tick)
    );

    adc_spi_rx_multi #(.SIGNED_IN(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .SDATA(SDATA),
        .CS(cs_s), .SCLK(sclk_s), .busy(busy_s), .rx_done_tick(rx_s),
        .data_out(data_s), .overrun_tick(ov_s)
    );

    always #5 clk = ~clk;

    // ADC lanes: MSB presented on the first SCLK fall, sampled by the master on the rise
    initial begin
        int bitpos;
        bitpos = 15;
        SDATA = 2'b00;
        forever begin
            @(negedge CS or negedge SCLK);
            if (!CS && !SCLK) begin
                if (bitpos >= 0) SDATA = {w1[bitpos], w0[bitpos]};
                bitpos--;
            end else begin
                bitpos = 15;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_done_tick) rx_cnt++;
        if (overrun_tick) ov_cnt++;
        if (!CS && SCLK && !prev_sclk) sclk_rises++;
        if (CS && !prev_cs) last_low = low_run;
        if (!CS && prev_cs) begin
            last_high   = high_run;
            fall_period = cyc - last_fall;
            last_fall   = cyc;
        end
        low_run   = CS ? 0 : low_run + 1;
        high_run  = CS ? high_run + 1 : 0;
        prev_cs   = CS;
        prev_sclk = SCLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int k = 0; k < budget && rx_cnt < target; k++) @(negedge clk);
        chk("rx_wait", rx_cnt >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) @(negedge clk);
        chk("idle_wait", busy, 1'b0);
    endtask

`ifdef ADC_AVG_EN
    logic [15:0] avg_w [4] = '{16'h080A, 16'h080B, 16'h080C, 16'h080E};
`else
    // {w1, w0, expected unsigned {ch1,ch0}, expected signed-input {ch1,ch0}}
    logic [95:0] vec [3] = '{
        {16'h0800, 16'h0FFF, 32'h0000_07FF, 32'hF800_FFFF},
        {16'h0801, 16'h0000, 32'h0001_F800, 32'hF801_0000},
        {16'h07FF, 16'h0800, 32'hFFFF_0000, 32'h07FF_F800}
    };
`endif

    initial begin
        int s_rx, s_ov, s_sc;
        repeat (3) @(negedge clk);
        chk("rst_cs", CS, 1'b1);
        chk("rst_sclk", SCLK, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tick", rx_done_tick, 1'b0);
        chk("rst_ovr", overrun_tick, 1'b0);
        chk("rst_data", data_out, 32'h0);
        reset = 1'b1;
        @(negedge clk);
`ifdef ADC_AVG_EN
        s_rx = rx_cnt;
        w1 = 16'h0800;
        for (int k = 0; k < 4; k++) begin
            w0 = avg_w[k];
            pulse_start();
            wait_idle(300);
            if (k == 2) chk("avg_no_tick", rx_cnt - s_rx, 0);
        end
        chk("avg_ticks", rx_cnt - s_rx, 1);
        chk("avg_ch0", data_out[15:0], 16'd11);
        chk("avg_ch1", data_out[31:16], 16'h0000);
        chk("avg_s_ch0", data_s[15:0], 16'hF80B);
        chk("avg_s_ch1", data_s[31:16], 16'hF800);
`else
        for (int v = 0; v < 3; v++) begin
            {w1, w0} = vec[v][95:64];
            s_rx = rx_cnt;
            s_sc = sclk_rises;
            pulse_start();
            wait_rx(s_rx + 1, 300);
            chk("single_tick", rx_done_tick, 1'b1);
            chk("single_cs_at_tick", CS, 1'b1);
            chk("single_cs_low", last_low, 132);
            chk("single_sclk_rises", sclk_rises - s_sc, 16);
            chk("single_data", data_out, vec[v][63:32]);
            chk("single_data_signed", data_s, vec[v][31:0]);
            @(negedge clk);
            chk("single_tick_once", rx_done_tick, 1'b0);
            wait_idle(50);
            repeat (20) @(negedge clk);
            chk("single_rx_count", rx_cnt - s_rx, 1);
            chk("single_hold", data_out, vec[v][63:32]);
        end

        w0 = 16'h0123; w1 = 16'h0ABC;
        s_rx = rx_cnt; s_ov = ov_cnt;
        continuous = 1'b1;
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        wait_rx(s_rx + 2, 320);
        chk("cont_period", fall_period, 140);
        chk("cont_cs_high", last_high, 8);
        for (int k = 0; k < 20 && CS; k++) @(negedge clk);
        chk("cont_third_fall", CS, 1'b0);
        continuous = 1'b0;
        wait_rx(s_rx + 3, 320);
        chk("cont_period3", fall_period, 140);
        chk("cont_cs_high3", last_high, 8);
        chk("cont_data", data_out, 32'h02BC_F923);
        wait_idle(50);
        repeat (200) @(negedge clk);
        chk("cont_frames", rx_cnt - s_rx, 3);
        chk("cont_no_overrun", ov_cnt - s_ov, 0);

        w0 = 16'h0555; w1 = 16'h0AAA;
        s_rx = rx_cnt; s_ov = ov_cnt;
        pulse_start();
        repeat (19) @(negedge clk);
        pulse_start();
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("queue_overrun_pulse", overrun_tick, 1'b1);
        wait_rx(s_rx + 1, 300);
        wait_rx(s_rx + 2, 300);
        chk("queue_period", fall_period, 140);
        chk("queue_overruns", ov_cnt - s_ov, 1);
        chk("queue_data", data_out, 32'h02AA_FD55);
        wait_idle(50);
        repeat (200) @(negedge clk);
        chk("queue_frames", rx_cnt - s_rx, 2);

        s_sc = sclk_rises;
        pulse_start();
        for (int k = 0; k < 200 && sclk_rises - s_sc < 7; k++) @(negedge clk);
        chk("rst_mid_edges", sclk_rises - s_sc, 7);
        reset = 1'b0;
        #1;
        chk("rst_mid_cs", CS, 1'b1);
        chk("rst_mid_sclk", SCLK, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_data", data_out, 32'h0);
        chk("rst_mid_data_s", data_s, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        w0 = 16'h0FFF; w1 = 16'h0800;
        s_rx = rx_cnt; s_sc = sclk_rises;
        pulse_start();
        wait_rx(s_rx + 1, 300);
        chk("post_rst_cs_low", last_low, 132);
        chk("post_rst_sclk", sclk_rises - s_sc, 16);
        chk("post_rst_data", data_out, 32'h0000_07FF);
        wait_idle(50);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
